// File: rtl/txn_bus_master.sv
// rtl/txn_bus_master.sv - Command-queued two-phase bus master with registered read response
module txn_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
endmodule

module txn_bus_master #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic                     rsp_ready,
    output logic                     sel,
    output logic                     en,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     wr_en,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q;
    logic                sel_q;
    logic                en_q;
    logic                wr_en_q;
    logic                rsp_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                push;
    logic                pop;
    logic [EW-1:0]       head;

    // Ready looks only at the registered count so a same-cycle pop never opens a slot
    assign cmd_ready = !reset && (fifo_count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (fifo_count != '0);

    txn_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd_wr, cmd_addr, cmd_wdata}),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        wr_en_q   <= head[EW-1];
                        addr_q    <= head[DATA_W +: ADDR_W];
                        wr_data_q <= head[DATA_W-1:0];
                        sel_q     <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    en_q    <= 1'b1;
                    state_q <= ACCESS;
                end
                // wr_en_q still holds the transfer direction on the exit edge
                ACCESS: begin
                    sel_q   <= 1'b0;
                    en_q    <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (wr_en_q) begin
                        state_q <= IDLE;
                    end else begin
                        rsp_rdata_q <= rd_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel       = sel_q;
    assign en        = en_q;
    assign wr_en     = wr_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
endmodule
